// File: rtl/output_display_queue.sv
// output_display_queue: queues CPU OUT values and holds each on the display for HOLD_CYCLES clocks
module output_display_queue #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   out_strobe,
  input  logic [DATA_W-1:0]      out_data,
  input  logic                   flush,
  output logic [DATA_W-1:0]      disp_value,
  output logic                   disp_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   cpu_stall,
  output logic                   overflow,
  output logic [7:0]             drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [HW-1:0] hold_cnt;
  logic strobe_q, push, full, hold_end, holding, pop, wr_en, drop;
  always_comb begin
    push     = out_strobe & ~strobe_q;
    full     = fifo_count == (AW+1)'(DEPTH);
    hold_end = hold_cnt == HW'(HOLD_CYCLES - 1);
    holding  = (state == SHOW) & ~hold_end;
    // a flush cycle never pops, so the current display just runs out its hold
    pop      = ~flush & (fifo_count != '0) & ((state == IDLE) | hold_end);
    wr_en    = push & ~flush & (~full | pop);
    drop     = push & ~flush & full & ~pop;
  end
  assign cpu_stall = full;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= out_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      disp_value <= '0;
      disp_busy  <= 1'b0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold_cnt   <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q   <= out_strobe;
      wr_ptr     <= wr_ptr + AW'(wr_en);
      rd_ptr     <= flush ? wr_ptr : rd_ptr + AW'(pop);
      fifo_count <= flush ? '0 : fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow   <= overflow | drop;
      drop_count <= (drop && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
      disp_value <= pop ? mem[rd_ptr] : disp_value;
      hold_cnt   <= holding ? hold_cnt + HW'(1) : '0;
      state      <= (pop | holding) ? SHOW : IDLE;
      disp_busy  <= pop | holding;
    end
  end
endmodule

// File: tb/tb_output_display_queue.sv
// tb_output_display_queue: randomized bench against a queue/timer reference model
module tb_output_display_queue;
  localparam int D = 4, H = 4;
  logic clk = 0, reset = 0, out_strobe = 0, flush = 0;
  logic [31:0] out_data = 0, disp_value;
  logic disp_busy, cpu_stall, overflow;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mq[$];
  logic [31:0] m_disp;
  bit m_busy, m_prev, m_ovf;
  int m_left, m_drops, peak;

  output_display_queue #(.DATA_W(32), .DEPTH(D), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .out_strobe(out_strobe), .out_data(out_data), .flush(flush),
    .disp_value(disp_value), .disp_busy(disp_busy), .fifo_count(fifo_count),
    .cpu_stall(cpu_stall), .overflow(overflow), .drop_count(drop_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_disp = 0; m_busy = 0; m_prev = 0; m_ovf = 0; m_left = 0; m_drops = 0;
  endtask

  // each value is shown for H cycles; a new one is taken only when the old one expires
  task automatic model_step();
    bit rise, pop, was_full;
    rise = out_strobe && !m_prev;
    m_prev = out_strobe;
    was_full = mq.size() == D;
    pop = !flush && mq.size() > 0 && (!m_busy || m_left == 1);
    if (m_busy && m_left > 1) m_left--;
    else if (pop) begin
      m_disp = mq.pop_front(); m_busy = 1; m_left = H;
    end else m_busy = 0;
    if (flush) mq.delete();
    else if (rise) begin
      if (was_full && !pop) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end else mq.push_back(out_data);
    end
  endtask

  task automatic check_all();
    chk("disp_value", disp_value, m_disp);
    chk("disp_busy", disp_busy, m_busy);
    chk("fifo_count", fifo_count, mq.size());
    chk("cpu_stall", cpu_stall, mq.size() == D);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
  endtask

  task automatic tick(input bit s, input bit f, input logic [31:0] d);
    out_strobe = s; flush = f; out_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (fifo_count > peak) peak = fifo_count;
  endtask

  initial begin
    bit s;
    int pct;
    model_reset();
    #2 check_all();
    @(negedge clk); reset = 1;
    for (int i = 0; i < 10; i++) tick(1, 0, 32'h2A);
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    chk("single_hold", disp_value, 32'h2A);
    peak = 0;
    for (int v = 1; v <= 3; v++) begin
      tick(1, 0, v); tick(0, 0, 0);
    end
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    chk("burst_peak", peak, 2);
    tick(1, 0, 9); tick(0, 0, 0); tick(0, 0, 0);
    for (int v = 10; v <= 15; v++) begin
      tick(1, 0, v); tick(0, 0, 0);
    end
    for (int i = 0; i < 40; i++) tick(0, 0, 0);
    for (int v = 20; v <= 23; v++) begin
      tick(1, 0, v); tick(0, 0, 0);
    end
    tick(1, 1, 32'hDEAD);
    chk("flush_count", fifo_count, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 0);
    chk("flush_idle", disp_busy, 0);
    for (int v = 30; v <= 33; v++) begin
      tick(1, 0, v); tick(0, 0, 0);
    end
    #2 reset = 0;
    model_reset();
    #1 check_all();
    @(negedge clk); reset = 1; out_strobe = 0;
    s = 0;
    for (int seg = 0; seg < 6; seg++) begin
      pct = $urandom_range(5, 90);
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 99) < pct) s = !s;
        tick(s, $urandom_range(0, 49) == 0, $urandom);
      end
    end
    for (int i = 0; i < 1400; i++) tick(i[0], 0, $urandom);
    chk("sat_drops", drop_count, 255);
    chk("sat_overflow", overflow, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
